// File: rtl/vend_pkg.sv
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared types and constants for the vending change path:
//                money width, default coin denominations, payout state
//                encoding and the coin tube index type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

  // Width of every money quantity (amounts, denominations, shortfall)
  localparam int DEN_W     = 8;
  localparam int NUM_TUBES = 4;

  // Default denominations, largest first
  localparam logic [DEN_W-1:0] c_den0_def = 8'd25;
  localparam logic [DEN_W-1:0] c_den1_def = 8'd10;
  localparam logic [DEN_W-1:0] c_den2_def = 8'd5;
  localparam logic [DEN_W-1:0] c_den3_def = 8'd1;

  // Payout sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } payout_state_t;

  // Index of one of the four coin tubes
  typedef logic [1:0] tube_idx_t;

endpackage

`default_nettype wire

// File: rtl/coin_tube_counter.sv
// ============================================================================
//  Module      : coin_tube_counter
//  Description : Inventory counter for one coin tube. Loads TUBE_INIT on
//                reset, adds refills with saturation, removes one coin per
//                eject, merges a same-cycle refill and eject without losing
//                the eject, and produces a registered low-stock flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_tube_counter #(
  parameter int TUBE_W    = 6,
  parameter int TUBE_INIT = 20,
  parameter int LOW_MARK  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc_valid,
  input  logic [TUBE_W-1:0] i_inc_count,
  input  logic              i_dec,
  output logic [TUBE_W-1:0] o_count,
  output logic              o_low
);

  localparam logic [TUBE_W:0]   c_sat_max  = {1'b0, {TUBE_W{1'b1}}};
  localparam logic [TUBE_W:0]   c_one      = (TUBE_W+1)'(1);
  localparam logic [TUBE_W-1:0] c_init     = TUBE_W'(TUBE_INIT);
  localparam logic              c_init_low = (TUBE_INIT < LOW_MARK);

  logic [TUBE_W-1:0] r_count;
  logic              r_low;
  logic [TUBE_W:0]   w_sum;
  logic [TUBE_W:0]   w_net;
  logic [TUBE_W-1:0] w_count_nxt;

  // Refill first, then take the ejected coin, one bit wider so the clamp
  // sees the true total (count + refill - 1 is clamped only at the end)
  always_comb begin
    w_sum = {1'b0, r_count};
    if (i_inc_valid) begin
      w_sum = w_sum + {1'b0, i_inc_count};
    end
    w_net = w_sum;
    if (i_dec && (w_sum != '0)) begin
      w_net = w_sum - c_one;
    end
    w_count_nxt = (w_net > c_sat_max) ? c_sat_max[TUBE_W-1:0] : w_net[TUBE_W-1:0];
  end

  // Count register and low flag; the flag trails the count by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= c_init;
      r_low   <= c_init_low;
    end else begin
      r_count <= w_count_nxt;
      r_low   <= (int'(r_count) < LOW_MARK);
    end
  end

  assign o_count = r_count;
  assign o_low   = r_low;

endmodule

`default_nettype wire

// File: rtl/change_payout_ctrl.sv
// ============================================================================
//  Module      : change_payout_ctrl
//  Description : Pays a change amount out one coin at a time, largest
//                denomination first, handshaking each coin with the hopper.
//                Tracks four coin tubes, accepts refills at any time and
//                reports the amount that could not be paid.
//  Options     : `define CHANGE_TIMEOUT_EN to add a hopper ack timeout with
//                a sticky fault; when undefined WAIT_ACK waits forever and
//                fault is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_payout_ctrl
  import vend_pkg::*;
#(
  parameter logic [DEN_W-1:0] DEN0        = c_den0_def,
  parameter logic [DEN_W-1:0] DEN1        = c_den1_def,
  parameter logic [DEN_W-1:0] DEN2        = c_den2_def,
  parameter logic [DEN_W-1:0] DEN3        = c_den3_def,
  parameter int               TUBE_W      = 6,
  parameter int               TUBE_INIT   = 20,
  parameter int               LOW_MARK    = 2,
  parameter int               TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 change_valid,
  input  logic [DEN_W-1:0]     change_amount,
  output logic                 busy,
  output logic                 eject_req,
  output logic [1:0]           eject_sel,
  input  logic                 eject_ack,
  input  logic                 refill_valid,
  input  logic [1:0]           refill_sel,
  input  logic [TUBE_W-1:0]    refill_count,
  output logic [NUM_TUBES-1:0] tube_low,
  output logic                 done,
  output logic [DEN_W-1:0]     shortfall,
  output logic                 fault
);

  // Reject parameter sets that break the greedy ordering or the counters
  if (!((DEN0 > DEN1) && (DEN1 > DEN2) && (DEN2 > DEN3) && (DEN3 > 0) &&
        (TIMEOUT_CYC > 0) && (TUBE_INIT < (1 << TUBE_W)))) begin : g_bad_params
    $error("change_payout_ctrl: illegal parameter set");
  end

  payout_state_t      r_state;
  payout_state_t      w_state_nxt;
  logic [DEN_W-1:0]   r_remaining;
  logic [DEN_W-1:0]   w_remaining_nxt;
  logic [DEN_W-1:0]   r_shortfall;
  logic [DEN_W-1:0]   w_shortfall_nxt;
  tube_idx_t          r_sel;
  tube_idx_t          w_sel_nxt;
  logic               r_eject_req;
  logic               w_eject_req_nxt;
  logic               w_coin_taken;
  logic               w_fault;

  logic [DEN_W-1:0]   w_den   [NUM_TUBES];
  logic [TUBE_W-1:0]  w_count [NUM_TUBES];
  logic [NUM_TUBES-1:0] w_refill;
  logic [NUM_TUBES-1:0] w_dec;

  logic               w_found;
  tube_idx_t          w_pick;

  assign w_den[0] = DEN0;
  assign w_den[1] = DEN1;
  assign w_den[2] = DEN2;
  assign w_den[3] = DEN3;

  // One inventory counter per tube; an eject decrements only the selected tube
  for (genvar g = 0; g < NUM_TUBES; g++) begin : g_tube
    assign w_refill[g] = refill_valid && (refill_sel == tube_idx_t'(g));
    assign w_dec[g]    = w_coin_taken && (r_sel == tube_idx_t'(g));

    coin_tube_counter #(
      .TUBE_W    (TUBE_W),
      .TUBE_INIT (TUBE_INIT),
      .LOW_MARK  (LOW_MARK)
    ) u_tube (
      .clk         (clk),
      .reset       (reset),
      .i_inc_valid (w_refill[g]),
      .i_inc_count (refill_count),
      .i_dec       (w_dec[g]),
      .o_count     (w_count[g]),
      .o_low       (tube_low[g])
    );
  end

  // Greedy pick: lowest-index (largest) coin that fits and is in stock.
  // Scanning downwards lets the lowest qualifying index win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = NUM_TUBES-1; i >= 0; i--) begin
      if ((w_den[i] <= r_remaining) && (w_count[i] != '0)) begin
        w_found = 1'b1;
        w_pick  = tube_idx_t'(i);
      end
    end
  end

`ifdef CHANGE_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_fault;
  logic              w_timeout;
  logic              w_fault_set;

  // Cycles spent waiting on the current coin; restarts for every coin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if ((r_state == WAIT_ACK) && !eject_ack) begin
      r_to_cnt <= r_to_cnt + c_to_w'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == WAIT_ACK) && (r_to_cnt == c_to_w'(TIMEOUT_CYC - 1));
  assign w_fault_set = w_timeout && !eject_ack;

  // Hopper fault stays set until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  // Next-state and datapath decisions for the payout sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_shortfall_nxt = r_shortfall;
    w_sel_nxt       = r_sel;
    w_eject_req_nxt = 1'b0;
    w_coin_taken    = 1'b0;
    case (r_state)
      IDLE: begin
        if (change_valid && (change_amount != '0)) begin
          w_remaining_nxt = change_amount;
          w_shortfall_nxt = '0;
          if (w_fault) begin
            // A faulted hopper pays nothing: the whole amount is short
            w_shortfall_nxt = change_amount;
            w_state_nxt     = DONE;
          end else begin
            w_state_nxt = SELECT;
          end
        end
      end
      SELECT: begin
        if (w_found) begin
          w_sel_nxt       = w_pick;
          w_eject_req_nxt = 1'b1;
          w_state_nxt     = WAIT_ACK;
        end else begin
          w_shortfall_nxt = r_remaining;
          w_state_nxt     = DONE;
        end
      end
      WAIT_ACK: begin
        if (eject_ack) begin
          // Selection guaranteed the coin fits, so this cannot underflow
          w_coin_taken    = 1'b1;
          w_remaining_nxt = r_remaining - w_den[r_sel];
          w_state_nxt     = SELECT;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (w_timeout) begin
          w_shortfall_nxt = r_remaining;
          w_state_nxt     = DONE;
        end
`endif
        else begin
          w_eject_req_nxt = 1'b1;
        end
      end
      DONE: begin
        w_remaining_nxt = '0;
        w_state_nxt     = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_shortfall <= '0;
      r_sel       <= '0;
      r_eject_req <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_shortfall <= w_shortfall_nxt;
      r_sel       <= w_sel_nxt;
      r_eject_req <= w_eject_req_nxt;
    end
  end

  assign busy      = (r_state == SELECT) || (r_state == WAIT_ACK);
  assign done      = (r_state == DONE);
  assign eject_req = r_eject_req;
  assign eject_sel = r_sel;
  assign shortfall = r_shortfall;
  assign fault     = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_change_payout_ctrl.sv
// ============================================================================
//  Module      : tb_change_payout_ctrl
//  Description : Self-checking bench for change_payout_ctrl: table of
//                directed payouts, refill/saturation and reset corner cases,
//                randomized payouts against a greedy inventory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_change_payout_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       change_valid = 1'b0;
  logic [7:0] change_amount = '0;
  logic       busy;
  logic       eject_req;
  logic [1:0] eject_sel;
  logic       eject_ack = 1'b0;
  logic       refill_valid = 1'b0;
  logic [1:0] refill_sel = '0;
  logic [5:0] refill_count = '0;
  logic [3:0] tube_low;
  logic       done;
  logic [7:0] shortfall;
  logic       fault;

  change_payout_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .busy          (busy),
    .eject_req     (eject_req),
    .eject_sel     (eject_sel),
    .eject_ack     (eject_ack),
    .refill_valid  (refill_valid),
    .refill_sel    (refill_sel),
    .refill_count  (refill_count),
    .tube_low      (tube_low),
    .done          (done),
    .shortfall     (shortfall),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         amount;
    int         ack_delay;
    int         exp_coins;
    int         exp_sf;
    logic [3:0] exp_low;
    int         exp_lat;   // 0 = latency not checked
  } vec_t;

  vec_t tbl [7];

  int n_vec = 0;
  int n_bad = 0;
  int m_tube [4];
  int exp_q [$];
  int got_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int den_of(input int i);
    case (i)
      0: return 25;
      1: return 10;
      2: return 5;
      default: return 1;
    endcase
  endfunction

  // Greedy payout in closed form: take as many of each coin as fit and exist
  function automatic void model_pay(input int amt, output int sf);
    int rem;
    rem = amt;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      int n;
      n = rem / den_of(i);
      if (n > m_tube[i]) n = m_tube[i];
      repeat (n) exp_q.push_back(i);
      m_tube[i] = m_tube[i] - n;
      rem = rem - n * den_of(i);
    end
    sf = rem;
  endfunction

  function automatic int model_low();
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) if (m_tube[i] < 2) v = v | (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tube[i] = 20;
  endtask

  task automatic do_refill(input int sel, input int cnt);
    @(negedge clk);
    refill_valid = 1'b1;
    refill_sel   = sel[1:0];
    refill_count = cnt[5:0];
    @(negedge clk);
    refill_valid = 1'b0;
    m_tube[sel] = (m_tube[sel] + cnt > 63) ? 63 : m_tube[sel] + cnt;
  endtask

  // One full transaction with a hopper that acks after ack_delay cycles
  task automatic run_txn(input string tag, input int amt, input int ack_delay,
                         output int n_coins, output int sf, output int lat);
    int exp_sf;
    int req_cycles;
    bit seen_done;
    model_pay(amt, exp_sf);
    got_q.delete();
    req_cycles = 0;
    seen_done  = 1'b0;
    sf  = -1;
    lat = -1;
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = amt[7:0];
    for (int c = 1; c <= 4000 && !seen_done; c++) begin
      @(negedge clk);
      change_valid = 1'b0;
      eject_ack    = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        sf  = int'(shortfall);
        lat = c;
      end else if (eject_req) begin
        req_cycles++;
        if (req_cycles >= ack_delay) begin
          eject_ack = 1'b1;
          got_q.push_back(int'(eject_sel));
          req_cycles = 0;
        end
      end
    end
    eject_ack = 1'b0;
    check({tag, " done"}, int'(seen_done), 1);
    check({tag, " coins"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check({tag, " sel"}, got_q[k], exp_q[k]);
    check({tag, " shortfall"}, sf, exp_sf);
    check({tag, " tube_low"}, int'(tube_low), model_low());
    n_coins = got_q.size();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int coins, sfv, lat, any, seen, reqc;

  initial begin
    // From reset (20 coins per tube); each row continues from the previous
    tbl[0] = '{40,  3, 3,  0,  4'b0000, 0};
    tbl[1] = '{250, 2, 10, 0,  4'b0000, 0};
    tbl[2] = '{250, 1, 12, 0,  4'b0001, 0};
    tbl[3] = '{40,  3, 4,  0,  4'b0001, 0};
    tbl[4] = '{7,   2, 3,  0,  4'b0001, 0};
    tbl[5] = '{255, 1, 48, 22, 4'b1111, 0};
    tbl[6] = '{7,   1, 0,  7,  4'b1111, 2};

    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst busy", int'(busy), 0);
    check("rst eject_req", int'(eject_req), 0);
    check("rst eject_sel", int'(eject_sel), 0);
    check("rst done", int'(done), 0);
    check("rst shortfall", int'(shortfall), 0);
    check("rst fault", int'(fault), 0);
    check("rst tube_low", int'(tube_low), 0);

    // Zero amount is ignored entirely
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = 8'd0;
    any = 0;
    repeat (4) begin
      @(negedge clk);
      change_valid = 1'b0;
      if (busy || done || eject_req) any = 1;
    end
    check("zero amount ignored", any, 0);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].amount, tbl[i].ack_delay, coins, sfv, lat);
      check($sformatf("tbl%0d exp coins", i), coins, tbl[i].exp_coins);
      check($sformatf("tbl%0d exp shortfall", i), sfv, tbl[i].exp_sf);
      check($sformatf("tbl%0d exp low", i), int'(tube_low), int'(tbl[i].exp_low));
      if (tbl[i].exp_lat != 0) check($sformatf("tbl%0d latency", i), lat, tbl[i].exp_lat);
    end

    // Refill on the very cycle the last coin of tube 3 is acked
    do_refill(3, 1);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = 8'd1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      change_valid = 1'b0;
      if (eject_req) seen = 1;
    end
    check("refill eject_req", seen, 1);
    check("refill busy", int'(busy), 1);
    check("refill sel", int'(eject_sel), 3);
    eject_ack    = 1'b1;
    refill_valid = 1'b1;
    refill_sel   = 2'd3;
    refill_count = 6'd5;
    @(negedge clk);
    eject_ack    = 1'b0;
    refill_valid = 1'b0;
    check("low3 lags", int'(tube_low[3]), 1);
    @(negedge clk);
    check("low3 clears", int'(tube_low[3]), 0);
    check("refill done", int'(done), 1);
    check("refill shortfall", int'(shortfall), 0);
    m_tube[3] = 5;

    // Saturating refill: 5 + 63 clamps to 63
    do_refill(3, 63);
    run_txn("sat", 255, 1, coins, sfv, lat);
    check("sat coins", coins, 63);
    check("sat shortfall", sfv, 192);

    // Randomized payouts against the inventory model
    for (int it = 0; it < 20; it++) begin
      do_refill($urandom_range(0, 3), $urandom_range(0, 20));
      do_refill($urandom_range(0, 3), $urandom_range(0, 20));
      run_txn($sformatf("rnd%0d", it), $urandom_range(1, 255), $urandom_range(1, 3),
              coins, sfv, lat);
    end

    // Reset in the middle of WAIT_ACK
    do_refill(0, 1);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = 8'd35;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      change_valid = 1'b0;
      if (eject_req) seen = 1;
    end
    check("pre-reset eject_req", seen, 1);
    reset = 1'b1;
    #1;
    check("mid rst busy", int'(busy), 0);
    check("mid rst eject_req", int'(eject_req), 0);
    check("mid rst done", int'(done), 0);
    check("mid rst shortfall", int'(shortfall), 0);
    check("mid rst tube_low", int'(tube_low), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_txn("post rst 35", 35, 2, coins, sfv, lat);
    check("post rst coins", coins, 2);
    check("post rst fault", int'(fault), 0);

`ifdef CHANGE_TIMEOUT_EN
    // Hopper never acks: timeout, sticky fault, whole amount short
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = 8'd25;
    reqc = 0;
    seen = 0;
    sfv  = -1;
    for (int c = 0; c < 1500 && seen == 0; c++) begin
      @(negedge clk);
      change_valid = 1'b0;
      if (eject_req) reqc++;
      if (done) begin
        seen = 1;
        sfv  = int'(shortfall);
      end
    end
    check("to done", seen, 1);
    check("to req cycles", reqc, 1000);
    check("to shortfall", sfv, 25);
    check("to fault", int'(fault), 1);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = 8'd10;
    any  = 0;
    seen = 0;
    sfv  = -1;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      change_valid = 1'b0;
      if (eject_req) any = 1;
      if (done) begin
        seen = 1;
        sfv  = int'(shortfall);
      end
    end
    check("fault done", seen, 1);
    check("fault no eject", any, 0);
    check("fault shortfall", sfv, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/change_payout_ctrl.md
Name: change_payout_ctrl

Overview:
Downstream of the vending FSM. It takes the change amount that the FSM produces after a dispense or a cancel, and pays it out one coin at a time to a coin hopper using a greedy largest-denomination-first algorithm. It tracks the inventory of four coin tubes, accepts refills, and reports any amount it could not pay. One payout transaction is in flight at a time; there is no queuing.

Parameters:
DEN0, 25, value of tube 0 coin (money units); largest
DEN1, 10, value of tube 1 coin
DEN2, 5, value of tube 2 coin
DEN3, 1, value of tube 3 coin; smallest; must satisfy DEN0>DEN1>DEN2>DEN3>0
TUBE_W, 6, tube counter width; saturates at 2^TUBE_W-1
TUBE_INIT, 20, count loaded into every tube on reset
LOW_MARK, 2, tube_low[i] asserted when tube i count < LOW_MARK
TIMEOUT_CYC, 1000, hopper ack timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
change_valid  in  1  single-cycle request; sampled only when busy=0
change_amount  in  8  amount to pay, sampled with change_valid
busy  out  1  transaction in progress
eject_req  out  1  hopper eject request; level, held until ack
eject_sel  out  2  tube to eject from; stable while eject_req=1
eject_ack  in  1  hopper has released one coin
refill_valid  in  1  refill strobe
refill_sel  in  2  tube being refilled
refill_count  in  TUBE_W  coins added
tube_low  out  4  registered per-tube low flags
done  out  1  one-cycle pulse at end of transaction
shortfall  out  8  unpaid amount; valid from done until the next accepted request
fault  out  1  sticky hopper fault

Behaviour:
- Reset (async): state=IDLE; remaining=0; all tubes=TUBE_INIT; busy, eject_req, eject_sel, done, shortfall and fault = 0; tube_low recomputed from TUBE_INIT.
- States: IDLE, SELECT, WAIT_ACK, DONE.
- IDLE:
  - change_valid=1 and change_amount>0: latch remaining; busy=1 from the next cycle; go to SELECT.
  - change_valid=1 and change_amount=0: ignored; no done pulse.
- SELECT (1 cycle):
  - Choose the lowest index i with DENi <= remaining and tube_i > 0.
  - If a tube is found: eject_sel=i, eject_req=1 next cycle, go to WAIT_ACK.
  - If remaining=0 or no tube qualifies: go to DONE with shortfall=remaining.
- WAIT_ACK:
  - Hold eject_req and eject_sel.
  - On the cycle eject_ack=1: tube_i decrements, remaining -= DENi, eject_req=0 next cycle, go to SELECT.
  - Minimum 2 cycles per coin.
  - eject_ack while eject_req=0 is ignored.
- DONE: done=1 for one cycle, busy=0, return to IDLE. change_valid is accepted from the cycle after done.
- change_valid while busy=1: ignored and dropped. Upstream must check busy.
- Refill: accepted in any state. tube[refill_sel] += refill_count, saturating. A refill and a decrement on the same tube in the same cycle give tube + refill_count - 1, saturated; the decrement is never lost.
- remaining never underflows, because selection guarantees DENi <= remaining.
- Greedy selection is required, not optimal selection. Example: 30 with tube 0 holding 25 and tubes 2 and 3 empty pays 25, then reports shortfall 5 (tube 1's 10 > 5).
- tube_low is registered and updates one cycle after a count changes.

Optional Feature:
- Macro: CHANGE_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT_ACK.
  - After TIMEOUT_CYC cycles without eject_ack: eject_req=0, fault=1 (sticky until reset), go to DONE with shortfall=remaining; the tube is not decremented.
  - While fault=1, an accepted request goes IDLE→DONE with shortfall=change_amount and no ejects.
- Disabled: no counter; WAIT_ACK waits indefinitely; fault is tied to 0.

Decomposition:
- Package vend_pkg: DEN_W=8, default denomination constants, payout state enum (IDLE/SELECT/WAIT_ACK/DONE), tube index type (2 bits).
- Sub-module coin_tube_counter: one instance per tube, TUBE_W wide. It handles reset load to TUBE_INIT, saturating add, decrement, combined same-cycle add/decrement, and the registered low flag.

Test Plan:
- Full tubes, change_amount=40 → ejects sel 0,1,2 (25,10,5), each acked after 3 cycles; done with shortfall=0; tube counts 19,19,19,20.
- Tube 0 preloaded empty via reset plus 20 ejects, change_amount=40 → four ejects sel 1; shortfall=0.
- Tubes 2 and 3 empty, change_amount=7 → no eject; done two cycles after request; shortfall=7.
- Tube 3 at 1 coin; refill_valid sel 3, count 5 on the same cycle as its eject_ack → tube 3 = 5; tube_low[3] deasserts one cycle later. Refill to 63 saturates.
- Assert reset while eject_req=1 in WAIT_ACK → all outputs 0 immediately, tubes=TUBE_INIT; the next change_valid=35 pays 25 then 10 normally.
- With CHANGE_TIMEOUT_EN, change_amount=25 and eject_ack never asserted → eject_req drops after 1000 cycles, fault=1, shortfall=25. A second request of 10 gives done with shortfall=10 and no eject_req.
